// File: rtl/rr_mux_arb.sv
// N-channel arbitrated multiplexer with a one-word registered output stage.
// Round-robin or fixed-priority grant; one word per cycle sustained throughput.
module rr_mux_arb #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned N     = 8,
    parameter int unsigned RR    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [$clog2(N)-1:0] out_sel,
    input  logic                 out_ready
);

    localparam int unsigned SW = $clog2(N);

    logic [SW-1:0]    ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SW-1:0]    out_sel_q, out_sel_d;

    logic             load_en;
    logic             grant_found;
    logic [SW-1:0]    grant_idx;
    logic [SW-1:0]    start;
    logic [SW-1:0]    cand_idx;
    logic [N-1:0]     grant_oh;
    logic [WIDTH-1:0] sel_data;
    logic             xfer;
    int unsigned      cand;
    int unsigned      next_ptr;

    // Reset gates load_en so nothing is accepted while reset is held.
    assign load_en = (!out_valid_q || out_ready) && reset;
    assign start   = (RR != 0) ? ptr_q : '0;

    // Scan upward from the pointer, wrapping modulo N; first requester wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        cand_idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand     = (32'(start) + k) % N;
            cand_idx = SW'(cand);
            if (!grant_found && in_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign xfer = load_en && grant_found;

    always_comb begin
        grant_oh = '0;
        if (xfer) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign in_ready = grant_oh;

    // One-hot driven mux keeps every other channel's bits out of the result.
    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_oh[i]) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        next_ptr    = (32'(grant_idx) + 1) % N;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = grant_idx;
            if (RR != 0) begin
                ptr_d = SW'(next_ptr);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: doc/rr_mux_arb.md
RR_MUX_ARB -- requirements
Module: rr_mux_arb

Interface
REQ-001 Parameter: WIDTH, default 4, data bits per channel.
REQ-002 Parameter: N, default 8, channel count; legal range 2..16.
REQ-003 Parameter: RR, default 1; 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-low reset.
REQ-006 Port: in_valid  input  N  per-channel request; bit i belongs to channel i.
REQ-007 Port: in_data  input  N*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH+WIDTH-1 : i*WIDTH].
REQ-008 Port: in_ready  output  N  one-hot or zero; bit i high means channel i's word is accepted this cycle.
REQ-009 Port: out_valid  output  1  output register holds a word.
REQ-010 Port: out_data  output  WIDTH  registered data of the granted channel.
REQ-011 Port: out_sel  output  $clog2(N)  index of the channel that supplied out_data.
REQ-012 Port: out_ready  input  1  downstream accepts the word when out_valid and out_ready are both high.

Function
REQ-013 load_en SHALL be (!out_valid || out_ready) && reset high; a transfer happens on a rising edge where load_en and |in_valid are both true.
REQ-014 Grant SHALL be combinational from in_valid and the priority pointer; at most one in_ready bit high; in_ready SHALL be zero when load_en is false or in_valid is zero.
REQ-015 RR=1: search starts at pointer ptr and runs upward modulo N; the first valid channel wins.
REQ-016 RR=1: after a transfer from channel g, ptr SHALL become (g+1) mod N; g=N-1 wraps ptr to 0.
REQ-017 RR=0: lowest-index valid channel wins; ptr SHALL stay at 0.
REQ-018 On a transfer, out_data, out_sel and out_valid=1 SHALL update on that edge; input-to-output latency is exactly 1 cycle.
REQ-019 If out_valid=1 and out_ready=0, out_data and out_sel SHALL hold, in_ready SHALL be 0, and ptr SHALL hold.
REQ-020 Simultaneous drain and load (out_valid=1, out_ready=1, in_valid nonzero): new word SHALL load on the same edge; sustained throughput is 1 word per cycle.
REQ-021 Drain without load (out_ready=1, in_valid=0): out_valid SHALL go 0 next edge; out_data and out_sel hold their last value; ptr SHALL hold.
REQ-022 No request and no pending word: state SHALL be unchanged.
REQ-023 in_valid deasserting while the channel is not granted is legal; it SHALL have no side effects.
REQ-024 Data integrity: out_data SHALL equal the granted channel's in_data slice exactly; no other channel's bits are used.

Reset
REQ-025 While reset=0 at a rising edge: out_valid=0, out_data=0, out_sel=0, ptr=0.
REQ-026 While reset=0, in_ready SHALL be all zero combinationally, so no word is accepted during reset.
REQ-027 Reset mid-operation (out_valid=1, out_ready=0) SHALL discard the held word and leave no transfer counted.
REQ-028 First edge with reset=1 SHALL behave as from the idle state, with ptr=0.

Verification
REQ-029 Reset, then N=8, WIDTH=4, RR=1, in_valid=8'hFF, channel i data=i+3, out_ready=1 constantly -> out_sel sequence 0,1,...,7,0 on consecutive cycles; out_data 3,4,...,10(4'hA),3; in_ready one-hot matches.
REQ-030 RR=1, only channel 7 valid (data 4'hC), then only channels 0 and 7 valid -> first grant 7 (out_data C); ptr wraps to 0; next grant 0, then 7.
REQ-031 RR=0, in_valid=8'b1010_0100 held, out_ready=1 -> out_sel=2 every cycle; channels 5 and 7 never granted.
REQ-032 Word loaded from channel 3 (data 4'h9), out_ready=0 for 4 cycles -> out_valid=1, out_data=9, out_sel=3 stable; in_ready=0; ptr stays 4; out_ready=1 then grants channel 4 first if valid.
REQ-033 out_valid=1, out_ready=0, reset=0 for one edge -> out_valid=0, out_data=0, out_sel=0, in_ready=0 during reset; after release, channel 0 wins over 1..7.
REQ-034 Sweep WIDTH in {1,2,3,5}, N in {2,5,8,16} with 40 random vectors each -> every transfer's out_data equals the expected in_data slice; no in_ready pulse without a matching output word.
